// File: rtl/edc_pkg.sv
// Shared widths, helper function and point payload for the squared-distance pipeline.
package edc_pkg;

    localparam int unsigned COORD_W_DEF = 8;
    localparam int unsigned IDX_W_DEF   = 10;

    // Wide enough for the worst-case sum of three squared COORD_W-bit differences.
    function automatic int unsigned dist_w(input int unsigned coord_w);
        return 2 * coord_w + 2;
    endfunction

    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic [COORD_W_DEF-1:0] z;
        logic [IDX_W_DEF-1:0]   idx;
    } point_t;

endpackage

// File: rtl/edc_sq_axis.sv
// One axis of the distance pipeline: registered |a-c|, then registered square.
module edc_sq_axis #(
    parameter  int unsigned COORD_W = 8,
    localparam int unsigned SQ_W    = 2 * COORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [COORD_W-1:0] a,
    input  logic [COORD_W-1:0] c,
    output logic [SQ_W-1:0]    sq
);

    logic [COORD_W-1:0] diff_c;
    logic [COORD_W-1:0] diff_q;

    // Unsigned absolute difference; no sign bit is needed since only its square is used.
    always_comb begin
        diff_c = (a >= c) ? (a - c) : (c - a);
    end

    // S1: capture the absolute difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
        end else if (en) begin
            diff_q <= diff_c;
        end
    end

    // S2: capture the square at full 2*COORD_W precision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq <= '0;
        end else if (en) begin
            sq <= SQ_W'(diff_q) * SQ_W'(diff_q);
        end
    end

endmodule

// File: rtl/edc_pipe.sv
// Three-stage squared-Euclidean-distance unit with radius test and per-group hit counter.
module edc_pipe
    import edc_pkg::*;
#(
    parameter  int unsigned COORD_W = COORD_W_DEF,
    parameter  int unsigned IDX_W   = IDX_W_DEF,
    parameter  int unsigned NSAMPLE = 32,
    parameter  int unsigned CNT_W   = 6,
    localparam int unsigned DIST_W  = dist_w(COORD_W),
    localparam int unsigned SQ_W    = 2 * COORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               grp_start,
    input  logic [COORD_W-1:0] cp_x,
    input  logic [COORD_W-1:0] cp_y,
    input  logic [COORD_W-1:0] cp_z,
    input  logic [DIST_W-1:0]  radius_sq,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [COORD_W-1:0] in_z,
    input  logic [IDX_W-1:0]   in_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIST_W-1:0]  distsquare,
    output logic [IDX_W-1:0]   out_idx,
    output logic               in_radius,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic               grp_full
);

    logic               en;
    logic [COORD_W-1:0] cp_x_q, cp_y_q, cp_z_q;
    logic [DIST_W-1:0]  rad_q;
    logic               v_s1, v_s2;
    logic [IDX_W-1:0]   idx_s1, idx_s2;
    logic [SQ_W-1:0]    sq_x, sq_y, sq_z;
    logic [DIST_W-1:0]  sum_c;

    // Single global advance: the whole pipe moves unless the output is stalled.
    always_comb begin
        en       = !out_valid || out_ready;
        in_ready = en;
        grp_full = (hit_cnt == CNT_W'(NSAMPLE));
        sum_c    = DIST_W'(sq_x) + DIST_W'(sq_y) + DIST_W'(sq_z);
    end

    // Centre point and radius, reloaded on each group start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cp_x_q <= '0;
            cp_y_q <= '0;
            cp_z_q <= '0;
            rad_q  <= '0;
        end else if (grp_start) begin
            cp_x_q <= cp_x;
            cp_y_q <= cp_y;
            cp_z_q <= cp_z;
            rad_q  <= radius_sq;
        end
    end

    edc_sq_axis #(.COORD_W(COORD_W)) u_ax_x (
        .clk(clk), .rst_n(rst_n), .en(en), .a(in_x), .c(cp_x_q), .sq(sq_x)
    );
    edc_sq_axis #(.COORD_W(COORD_W)) u_ax_y (
        .clk(clk), .rst_n(rst_n), .en(en), .a(in_y), .c(cp_y_q), .sq(sq_y)
    );
    edc_sq_axis #(.COORD_W(COORD_W)) u_ax_z (
        .clk(clk), .rst_n(rst_n), .en(en), .a(in_z), .c(cp_z_q), .sq(sq_z)
    );

    // Valid and index tags travel alongside the axis stages; bubbles are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_s1      <= 1'b0;
            v_s2      <= 1'b0;
            out_valid <= 1'b0;
            idx_s1    <= '0;
            idx_s2    <= '0;
            out_idx   <= '0;
        end else if (en) begin
            v_s1      <= in_valid;
            v_s2      <= v_s1;
            out_valid <= v_s2;
            idx_s1    <= in_idx;
            idx_s2    <= idx_s1;
            out_idx   <= idx_s2;
        end
    end

    // S3: sum the squares and test against the latched radius.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            distsquare <= '0;
            in_radius  <= 1'b0;
        end else if (en) begin
            distsquare <= sum_c;
            in_radius  <= (sum_c <= rad_q);
        end
    end

    // Hit counter: group start clears and beats a same-cycle counted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (grp_start) begin
            hit_cnt <= '0;
        end else if (out_valid && out_ready && in_radius && !grp_full) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_edc_pipe.sv
// Directed bench for edc_pipe: corners, mixed vectors, radius edge, saturation, stall, reset.
module tb_edc_pipe;
    import edc_pkg::*;

    localparam int unsigned CW = 8;
    localparam int unsigned IW = 10;
    localparam int unsigned DW = 18;
    localparam int unsigned NW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          grp_start;
    logic [CW-1:0] cp_x, cp_y, cp_z;
    logic [DW-1:0] radius_sq;
    logic          in_valid, in_ready;
    logic [CW-1:0] in_x, in_y, in_z;
    logic [IW-1:0] in_idx;
    logic          out_valid, out_ready;
    logic [DW-1:0] distsquare;
    logic [IW-1:0] out_idx;
    logic          in_radius;
    logic [NW-1:0] hit_cnt;
    logic          grp_full;

    int n_checks = 0;
    int n_fails  = 0;

    edc_pipe #(.COORD_W(CW), .IDX_W(IW), .NSAMPLE(2), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .grp_start(grp_start),
        .cp_x(cp_x), .cp_y(cp_y), .cp_z(cp_z), .radius_sq(radius_sq),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .distsquare(distsquare), .out_idx(out_idx), .in_radius(in_radius),
        .hit_cnt(hit_cnt), .grp_full(grp_full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_dist(input int x, input int y, input int z,
                                    input int cx, input int cy, input int cz);
        return (x - cx) * (x - cx) + (y - cy) * (y - cy) + (z - cz) * (z - cz);
    endfunction

    task automatic new_group(input int cx, input int cy, input int cz, input int r);
        cp_x      = CW'(cx);
        cp_y      = CW'(cy);
        cp_z      = CW'(cz);
        radius_sq = DW'(r);
        grp_start = 1'b1;
        tick();
        grp_start = 1'b0;
    endtask

    // Drive one beat into an empty pipe and check it appears exactly 3 cycles later.
    task automatic run_single(input string tag, input int x, input int y, input int z,
                              input int idx, input int exp_d, input logic exp_in);
        in_x = CW'(x); in_y = CW'(y); in_z = CW'(z); in_idx = IW'(idx);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
        tick();
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_dist"},  32'(distsquare), 32'(exp_d));
        check_eq({tag, "_idx"},   32'(out_idx), 32'(idx));
        check_eq({tag, "_inrad"}, 32'(in_radius), 32'(exp_in));
        tick();
        check_eq({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    point_t beats [6];

    initial begin
        int src;
        int rcv;
        rst_n = 1'b0; grp_start = 1'b0;
        cp_x = '0; cp_y = '0; cp_z = '0; radius_sq = '0;
        in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0; in_idx = '0;
        out_ready = 1'b1;
        tick(); tick();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_dist",  32'(distsquare), 32'd0);
        check_eq("rst_idx",   32'(out_idx), 32'd0);
        check_eq("rst_inrad", 32'(in_radius), 32'd0);
        check_eq("rst_cnt",   32'(hit_cnt), 32'd0);
        check_eq("rst_full",  32'(grp_full), 32'd0);
        rst_n = 1'b1;
        tick();

        // Corners
        new_group(0, 0, 0, 0);
        run_single("t2_max", 255, 255, 255, 1, 195075, 1'b0);
        new_group(255, 255, 255, 0);
        run_single("t2_rev", 0, 0, 0, 2, 195075, 1'b0);
        run_single("t2_zero", 255, 255, 255, 3, 0, 1'b1);
        check_eq("t2_cnt", 32'(hit_cnt), 32'd1);

        // Mixed vectors
        new_group(11, 63, 255, 262143);
        run_single("t3_a", 195, 191, 127, 5, 66624, 1'b1);
        new_group(255, 191, 223, 0);
        run_single("t3_b", 51, 15, 17, 1023, 115028, 1'b0);

        // Radius boundary and saturation at NSAMPLE=2
        new_group(0, 0, 0, 66624);
        check_eq("t5_clr", 32'(hit_cnt), 32'd0);
        run_single("t5_eq", 184, 128, 128, 10, 66624, 1'b1);
        check_eq("t5_cnt1", 32'(hit_cnt), 32'd1);
        run_single("t5_over", 255, 40, 0, 11, 66625, 1'b0);
        check_eq("t5_cnt1b", 32'(hit_cnt), 32'd1);
        run_single("t5_hit2", 0, 0, 0, 12, 0, 1'b1);
        check_eq("t5_cnt2", 32'(hit_cnt), 32'd2);
        check_eq("t5_full", 32'(grp_full), 32'd1);
        run_single("t5_hit3", 1, 1, 1, 13, 3, 1'b1);
        check_eq("t5_sat", 32'(hit_cnt), 32'd2);
        check_eq("t5_full2", 32'(grp_full), 32'd1);

        // grp_start coincident with a counted hit
        new_group(0, 0, 0, 66624);
        in_x = 8'd1; in_y = 8'd0; in_z = 8'd0; in_idx = 10'd20;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check_eq("t6_valid", 32'(out_valid), 32'd1);
        check_eq("t6_inrad", 32'(in_radius), 32'd1);
        radius_sq = '0;
        grp_start = 1'b1;
        tick();
        grp_start = 1'b0;
        check_eq("t6_clr", 32'(hit_cnt), 32'd0);
        check_eq("t6_gone", 32'(out_valid), 32'd0);
        run_single("t6_newr", 1, 0, 0, 21, 1, 1'b0);
        check_eq("t6_cnt", 32'(hit_cnt), 32'd0);

        // Backpressure: 6 back-to-back beats, out_ready low for 4 cycles
        new_group(100, 100, 100, 262143);
        for (int i = 0; i < 6; i++) begin
            beats[i].x   = CW'(i * 40);
            beats[i].y   = CW'(255 - i * 30);
            beats[i].z   = CW'(100 + i * 7);
            beats[i].idx = IW'(100 + i);
        end
        src = 0;
        rcv = 0;
        for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 8);
            in_valid  = (src < 6);
            if (src < 6) begin
                in_x = beats[src].x; in_y = beats[src].y;
                in_z = beats[src].z; in_idx = beats[src].idx;
            end
            #1;
            if (out_valid && !out_ready)
                check_eq("t4_stall_rdy", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                check_eq("t4_idx", 32'(out_idx), 32'(beats[rcv].idx));
                check_eq("t4_dist", 32'(distsquare),
                         32'(ref_dist(int'(beats[rcv].x), int'(beats[rcv].y), int'(beats[rcv].z),
                                      100, 100, 100)));
                rcv++;
            end
            if (in_valid && in_ready)
                src++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("t4_count", 32'(rcv), 32'd6);
        tick(); tick(); tick();
        check_eq("t4_nodup", 32'(out_valid), 32'd0);
        check_eq("t4_cnt", 32'(hit_cnt), 32'd2);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            in_x = 8'd7; in_y = 8'd7; in_z = 8'd7; in_idx = IW'(200 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("t1_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t1_valid", 32'(out_valid), 32'd0);
        check_eq("t1_cnt",   32'(hit_cnt), 32'd0);
        check_eq("t1_full",  32'(grp_full), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t1_stale", 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
